// File: rtl/issue_queue_age_select_if.sv
// Bundle of signals between the age-ordered issue controller (master side)
// and the reservation-station storage, dispatch and functional unit (slave side).
interface issue_queue_age_select_if #(
   parameter int QUEUE_DEPTH = 3
);
   localparam int AW = $clog2(QUEUE_DEPTH);

   logic                   dispatch_valid;
   logic                   dispatch_ready;
   logic                   rs_station_wen;
   logic [AW-1:0]          rs_station_waddr;
   logic [QUEUE_DEPTH-1:0] rs_queue_valid_bits;
   logic [QUEUE_DEPTH-1:0] incoming_valid_bits;
   logic [QUEUE_DEPTH-1:0] rs_ready_bits;
   logic                   fu_ready;
   logic                   rs_station_complete;
   logic [AW-1:0]          rs_station_raddr;
   logic                   issue_valid;
   logic [AW:0]            rs_occupancy;

   modport master (
      input  dispatch_valid, rs_queue_valid_bits, incoming_valid_bits,
             rs_ready_bits, fu_ready,
      output dispatch_ready, rs_station_wen, rs_station_waddr,
             rs_station_complete, rs_station_raddr, issue_valid, rs_occupancy
   );

   modport slave (
      output dispatch_valid, rs_queue_valid_bits, incoming_valid_bits,
             rs_ready_bits, fu_ready,
      input  dispatch_ready, rs_station_wen, rs_station_waddr,
             rs_station_complete, rs_station_raddr, issue_valid, rs_occupancy
   );
endinterface

// File: rtl/issue_queue_age_select.sv
// Allocate/select controller for an age-ordered reservation station.
// Dispatch gets the lowest free slot; issue picks the oldest valid+ready slot
// using an age matrix where age_q[i][j] = 1 means slot i is older than slot j.
// Allocation and selection are purely combinational (zero-cycle issue latency);
// only the age matrix and the occupancy count are registered.
module issue_queue_age_select #(
   parameter int QUEUE_DEPTH = 3
) (
   input  logic                      clk,
   input  logic                      rst_n,
   issue_queue_age_select_if.master  rs_if
);
   localparam int AW = $clog2(QUEUE_DEPTH);
   localparam int OW = AW + 1;

   logic [QUEUE_DEPTH-1:0][QUEUE_DEPTH-1:0] age_q;
   logic [QUEUE_DEPTH-1:0][QUEUE_DEPTH-1:0] age_d;
   logic [OW-1:0]                           occ_q;
   logic [OW-1:0]                           occ_d;

   logic                   free_any;
   logic [AW-1:0]          alloc_idx;
   logic                   wen;
   logic [QUEUE_DEPTH-1:0] cand;
   logic [QUEUE_DEPTH-1:0] blocked;
   logic [QUEUE_DEPTH-1:0] chosen;
   logic [AW-1:0]          sel_idx;
   logic                   cand_any;

   // Lowest-index free slot; scanning downward lets the lowest index win.
   always_comb begin
      free_any  = 1'b0;
      alloc_idx = '0;
      for (int i = QUEUE_DEPTH - 1; i >= 0; i--) begin
         if (!rs_if.rs_queue_valid_bits[i]) begin
            free_any  = 1'b1;
            alloc_idx = AW'(i);
         end
      end
   end

   assign wen = rs_if.dispatch_valid && free_any;

   // Oldest candidate: a ready, valid slot that no other candidate is older than.
   // Stale matrix rows of invalid slots are masked because they are never candidates.
   always_comb begin
      cand    = rs_if.rs_ready_bits & rs_if.rs_queue_valid_bits;
      blocked = '0;
      chosen  = '0;
      sel_idx = '0;
      for (int i = 0; i < QUEUE_DEPTH; i++) begin
         for (int j = 0; j < QUEUE_DEPTH; j++) begin
            if (cand[j] && age_q[j][i]) begin
               blocked[i] = 1'b1;
            end
         end
         chosen[i] = cand[i] && !blocked[i];
      end
      for (int i = QUEUE_DEPTH - 1; i >= 0; i--) begin
         if (chosen[i]) begin
            sel_idx = AW'(i);
         end
      end
   end

   assign cand_any = |cand;

   // Newly written slot becomes the youngest: its row clears, its column sets.
   always_comb begin
      age_d = age_q;
      if (wen) begin
         age_d[alloc_idx] = '0;
         for (int j = 0; j < QUEUE_DEPTH; j++) begin
            if (j != int'(alloc_idx)) begin
               age_d[j][alloc_idx] = 1'b1;
            end
         end
      end
   end

   // Occupancy tracks the station's next-cycle valid count.
   always_comb begin
      occ_d = '0;
      for (int i = 0; i < QUEUE_DEPTH; i++) begin
         occ_d = occ_d + OW'(rs_if.incoming_valid_bits[i]);
      end
   end

   // Age matrix and occupancy registers; reset empties both immediately.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         age_q <= '0;
         occ_q <= '0;
      end else begin
         age_q <= age_d;
         occ_q <= occ_d;
      end
   end

   assign rs_if.dispatch_ready      = free_any;
   assign rs_if.rs_station_wen      = wen;
   assign rs_if.rs_station_waddr    = alloc_idx;
   assign rs_if.rs_station_complete = rs_if.fu_ready && cand_any;
   assign rs_if.issue_valid         = rs_if.fu_ready && cand_any;
   assign rs_if.rs_station_raddr    = sel_idx;
   assign rs_if.rs_occupancy        = occ_q;
endmodule

// File: tb/tb_issue_queue_age_select.sv
// Bench for issue_queue_age_select: a directed vector table walks the main
// scenarios, then random traffic is compared to a timestamp-based station model.
module tb_issue_queue_age_select;
   localparam int D  = 3;
   localparam int AW = $clog2(D);

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   issue_queue_age_select_if #(.QUEUE_DEPTH(D)) bus ();

   issue_queue_age_select #(.QUEUE_DEPTH(D)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .rs_if (bus)
   );

   typedef struct {
      logic         dv;
      logic [D-1:0] rdy;
      logic         fu;
      logic [D-1:0] kill;
      int           dr;
      int           wen;
      int           wa;
      int           cp;
      int           ra;
      int           occ;
   } vec_t;

   int errors = 0;
   int checks = 0;

   // Reference model: per-slot valid and allocation timestamp
   logic [D-1:0] mvalid;
   int unsigned  seq [D];
   int unsigned  tick;
   int           occ_exp;
   int           e_dr, e_wen, e_wa, e_cp, e_ra;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic int popcnt(input logic [D-1:0] v);
      int n = 0;
      for (int i = 0; i < D; i++) n += int'(v[i]);
      return n;
   endfunction

   task automatic model_reset();
      mvalid  = '0;
      occ_exp = 0;
      for (int i = 0; i < D; i++) seq[i] = 0;
   endtask

   // One cycle: predict, drive, compare comb outputs before the edge, then commit.
   task automatic step(input logic dv, input logic [D-1:0] rdy, input logic fu,
                       input logic [D-1:0] kill);
      logic [D-1:0] inc;
      logic [D-1:0] cand;
      int best;
      @(negedge clk);
      e_dr = 0; e_wa = 0; e_wen = 0; e_cp = 0; e_ra = 0;
      for (int i = D - 1; i >= 0; i--) begin
         if (!mvalid[i]) begin e_dr = 1; e_wa = i; end
      end
      e_wen = (dv && e_dr != 0) ? 1 : 0;
      cand = rdy & mvalid;
      best = -1;
      for (int i = 0; i < D; i++) begin
         if (cand[i] && (best < 0 || seq[i] < seq[best])) best = i;
      end
      if (best >= 0) begin
         e_ra = best;
         e_cp = fu ? 1 : 0;
      end
      inc = mvalid & ~kill;
      if (e_cp != 0) inc[e_ra] = 1'b0;
      if (e_wen != 0) inc[e_wa] = 1'b1;

      bus.dispatch_valid      = dv;
      bus.rs_ready_bits       = rdy;
      bus.fu_ready            = fu;
      bus.rs_queue_valid_bits = mvalid;
      bus.incoming_valid_bits = inc;
      #1;
      check("dispatch_ready", int'(bus.dispatch_ready), e_dr);
      check("wen", int'(bus.rs_station_wen), e_wen);
      check("waddr", int'(bus.rs_station_waddr), e_wa);
      check("complete", int'(bus.rs_station_complete), e_cp);
      check("issue_valid", int'(bus.issue_valid), e_cp);
      check("raddr", int'(bus.rs_station_raddr), e_ra);
      check("occupancy", int'(bus.rs_occupancy), occ_exp);

      if (e_wen != 0) begin
         seq[e_wa] = tick;
         tick++;
      end
      mvalid  = inc;
      occ_exp = popcnt(inc);
   endtask

   vec_t vt [25];

   initial begin
      tick = 1;
      model_reset();
      //          dv rdy     fu kill    dr wen wa cp ra occ
      vt[0]  = '{1, 3'b000, 1, 3'b000, 1, 1, 0, 0, 0, 0};
      vt[1]  = '{1, 3'b000, 1, 3'b000, 1, 1, 1, 0, 0, 1};
      vt[2]  = '{1, 3'b000, 1, 3'b000, 1, 1, 2, 0, 0, 2};
      vt[3]  = '{0, 3'b111, 1, 3'b000, 0, 0, 0, 1, 0, 3};
      vt[4]  = '{0, 3'b111, 1, 3'b000, 1, 0, 0, 1, 1, 2};
      vt[5]  = '{0, 3'b111, 1, 3'b000, 1, 0, 0, 1, 2, 1};
      vt[6]  = '{1, 3'b000, 1, 3'b000, 1, 1, 0, 0, 0, 0};
      vt[7]  = '{1, 3'b000, 1, 3'b000, 1, 1, 1, 0, 0, 1};
      vt[8]  = '{1, 3'b000, 1, 3'b000, 1, 1, 2, 0, 0, 2};
      vt[9]  = '{1, 3'b000, 1, 3'b010, 0, 0, 0, 0, 0, 3};
      vt[10] = '{0, 3'b001, 1, 3'b000, 1, 0, 1, 1, 0, 2};
      vt[11] = '{1, 3'b000, 1, 3'b000, 1, 1, 0, 0, 0, 1};
      vt[12] = '{0, 3'b101, 1, 3'b000, 1, 0, 1, 1, 2, 2};
      vt[13] = '{0, 3'b101, 1, 3'b000, 1, 0, 1, 1, 0, 1};
      vt[14] = '{1, 3'b000, 1, 3'b000, 1, 1, 0, 0, 0, 0};
      vt[15] = '{1, 3'b000, 1, 3'b000, 1, 1, 1, 0, 0, 1};
      vt[16] = '{0, 3'b010, 0, 3'b000, 1, 0, 2, 0, 1, 2};
      vt[17] = '{0, 3'b010, 0, 3'b000, 1, 0, 2, 0, 1, 2};
      vt[18] = '{0, 3'b010, 0, 3'b000, 1, 0, 2, 0, 1, 2};
      vt[19] = '{0, 3'b010, 1, 3'b000, 1, 0, 2, 1, 1, 2};
      vt[20] = '{1, 3'b000, 1, 3'b000, 1, 1, 1, 0, 0, 1};
      vt[21] = '{1, 3'b001, 1, 3'b000, 1, 1, 2, 1, 0, 2};
      vt[22] = '{0, 3'b000, 1, 3'b000, 1, 0, 0, 0, 0, 2};
      vt[23] = '{0, 3'b000, 1, 3'b110, 1, 0, 0, 0, 0, 2};
      vt[24] = '{0, 3'b000, 1, 3'b000, 1, 0, 0, 0, 0, 0};

      // Reset with an empty station and dispatch pending; occupancy must hold 0
      rst_n                   = 1'b0;
      bus.dispatch_valid      = 1'b1;
      bus.rs_ready_bits       = '0;
      bus.fu_ready            = 1'b1;
      bus.rs_queue_valid_bits = '0;
      bus.incoming_valid_bits = 3'b111;
      #2;
      check("rst dispatch_ready", int'(bus.dispatch_ready), 1);
      check("rst wen", int'(bus.rs_station_wen), 1);
      check("rst waddr", int'(bus.rs_station_waddr), 0);
      check("rst complete", int'(bus.rs_station_complete), 0);
      check("rst occupancy", int'(bus.rs_occupancy), 0);
      @(posedge clk);
      @(posedge clk);
      #1;
      check("rst occupancy held", int'(bus.rs_occupancy), 0);
      @(negedge clk);
      bus.incoming_valid_bits = '0;
      rst_n = 1'b1;

      // Directed table
      for (int r = 0; r < 25; r++) begin
         step(vt[r].dv, vt[r].rdy, vt[r].fu, vt[r].kill);
         check($sformatf("vec%0d dispatch_ready", r), int'(bus.dispatch_ready), vt[r].dr);
         check($sformatf("vec%0d wen", r), int'(bus.rs_station_wen), vt[r].wen);
         check($sformatf("vec%0d waddr", r), int'(bus.rs_station_waddr), vt[r].wa);
         check($sformatf("vec%0d complete", r), int'(bus.rs_station_complete), vt[r].cp);
         check($sformatf("vec%0d raddr", r), int'(bus.rs_station_raddr), vt[r].ra);
         check($sformatf("vec%0d occupancy", r), int'(bus.rs_occupancy), vt[r].occ);
      end

      // Random traffic against the model
      for (int c = 0; c < 400; c++) begin
         logic [D-1:0] k;
         k = ($urandom_range(0, 15) == 0) ? D'($urandom) : '0;
         step($urandom_range(0, 2) != 0, D'($urandom), $urandom_range(0, 3) != 0, k);
      end

      // Reset mid-run with the station emptied alongside it
      @(negedge clk);
      bus.rs_queue_valid_bits = '0;
      bus.incoming_valid_bits = '0;
      rst_n = 1'b0;
      #1;
      check("midrun rst occupancy", int'(bus.rs_occupancy), 0);
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();
      for (int c = 0; c < 150; c++) begin
         logic [D-1:0] k;
         k = ($urandom_range(0, 15) == 0) ? D'($urandom) : '0;
         step($urandom_range(0, 2) != 0, D'($urandom), $urandom_range(0, 3) != 0, k);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
